// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam int DEF_N_FLOORS = 8;
    localparam int DEF_MOVE_CYC = 50_000_000;
    localparam int DEF_DOOR_CYC = 100_000_000;

    // Width of the shared travel/dwell counter; never narrower than one bit.
    function automatic int timer_width(input int move_cyc, input int door_cyc);
        int longest;
        longest = (move_cyc > door_cyc) ? move_cyc : door_cyc;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/elevator_ctrl_scan_sel.sv
// SCAN helper: reports whether the pending mask has a call at, ahead of,
// or behind the given floor relative to the travel direction.
module scan_sel
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = DEF_N_FLOORS,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                dir_up,
    output logic                here,
    output logic                ahead,
    output logic                behind
);

    logic [N_FLOORS-1:0] above_mask;
    logic [N_FLOORS-1:0] below_mask;
    logic [N_FLOORS-1:0] at_mask;
    logic                up_any;
    logic                down_any;

    // Build floor-relative masks and OR-reduce the pending calls through them.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        above_mask = '0;
        below_mask = '0;
        at_mask    = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            above_mask[i] = (i > int'(cur_floor));
            below_mask[i] = (i < int'(cur_floor));
            at_mask[i]    = (i == int'(cur_floor));
        end
        here     = |(pending & at_mask);
        up_any   = |(pending & above_mask);
        down_any = |(pending & below_mask);
        ahead    = dir_up ? up_any : down_any;
        behind   = dir_up ? down_any : up_any;
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches floor calls, serves them in the current
// direction before reversing, and times floor travel and door dwell.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = DEF_N_FLOORS,
    parameter int FLOOR_W  = $clog2(N_FLOORS),
    parameter int MOVE_CYC = DEF_MOVE_CYC,
    parameter int DOOR_CYC = DEF_DOOR_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                call_valid,
    input  logic [FLOOR_W-1:0]  call_floor,
    input  logic                door_hold,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                call_err
);

    localparam int TMR_W = timer_width(MOVE_CYC, DOOR_CYC);
    localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_CYC - 1);
    localparam logic [TMR_W-1:0] DOOR_LAST = TMR_W'(DOOR_CYC - 1);

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                dir_q, dir_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                err_q;

    logic [FLOOR_W-1:0]  nxt_floor;
    logic                here_c, ahead_c, behind_c;
    logic                nxt_here, nxt_ahead, nxt_behind_unused;
    logic                call_in_range, restart, call_ok;
    logic                clr_en;
    logic [FLOOR_W-1:0]  clr_floor;
    logic [N_FLOORS-1:0] set_mask, clr_mask;

    // Floor the car reaches when the current travel step completes.
    assign nxt_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    assign call_in_range = call_valid && (int'(call_floor) < N_FLOORS);
    // A call for the open-door floor only extends the dwell.
    assign restart       = (state_q == DOOR) && call_valid && (call_floor == floor_q);
    assign call_ok       = call_in_range && !restart;

    scan_sel #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
        .pending  (pend_q),
        .cur_floor(floor_q),
        .dir_up   (dir_q),
        .here     (here_c),
        .ahead    (ahead_c),
        .behind   (behind_c)
    );

    // Arrival decisions are taken on the floor being entered.
    scan_sel #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_nxt (
        .pending  (pend_q),
        .cur_floor(nxt_floor),
        .dir_up   (dir_q),
        .here     (nxt_here),
        .ahead    (nxt_ahead),
        .behind   (nxt_behind_unused)
    );

    // Next-state, position, direction and timer decisions.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        clr_en    = 1'b0;
        clr_floor = floor_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (here_c) begin
                    clr_en  = 1'b1;
                    state_d = DOOR;
                end else if (ahead_c) begin
                    state_d = MOVE;
                end else if (behind_c) begin
                    dir_d   = ~dir_q;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (timer_q == MOVE_LAST) begin
                    timer_d = '0;
                    floor_d = nxt_floor;
                    if (nxt_here) begin
                        clr_en    = 1'b1;
                        clr_floor = nxt_floor;
                        state_d   = DOOR;
                    end else if (nxt_ahead) begin
                        state_d = MOVE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DOOR: begin
                if (restart) begin
                    timer_d = '0;
                end else if (!door_hold) begin
                    if (timer_q == DOOR_LAST) begin
                        timer_d = '0;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Decode the call to set and the served floor to clear; clearing wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            set_mask[i] = call_ok && (int'(call_floor) == i);
            clr_mask[i] = clr_en && (int'(clr_floor) == i);
        end
        pend_d = (pend_q | set_mask) & ~clr_mask;
    end

    // State, position, pending calls and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            pend_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            err_q   <= call_valid && !call_in_range;
        end
    end

    assign cur_floor = floor_q;
    assign dir_up    = dir_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);
    assign pending   = pend_q;
    assign call_err  = err_q;

    // The car never steps beyond the top or bottom floor.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == MOVE && timer_q == MOVE_LAST)
            |-> (dir_q ? (int'(floor_q) < N_FLOORS - 1) : (floor_q != '0)));

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench: directed scenarios plus random calls, compared each
// cycle against a floor-level behavioural model of the elevator rules.
module tb_elevator_ctrl;

    localparam int N    = 8;
    localparam int FW   = 4;
    localparam int MOVE = 4;
    localparam int DOOR = 3;

    logic          clk;
    logic          rst;
    logic          call_valid;
    logic [FW-1:0] call_floor;
    logic          door_hold;
    logic [FW-1:0] cur_floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic [N-1:0]  pending;
    logic          call_err;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_ctrl #(.N_FLOORS(N), .FLOOR_W(FW), .MOVE_CYC(MOVE), .DOOR_CYC(DOOR)) dut (
        .clk       (clk),
        .rst       (rst),
        .call_valid(call_valid),
        .call_floor(call_floor),
        .door_hold (door_hold),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending),
        .call_err  (call_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_floor;
    bit m_up, m_moving, m_door, m_err;
    int m_timer;
    bit m_pend[N];

    function automatic bit any_beyond(input int f, input bit up);
        for (int i = 0; i < N; i++)
            if (m_pend[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_up = 1'b1; m_moving = 1'b0; m_door = 1'b0;
        m_err = 1'b0; m_timer = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_step(input bit v, input int fl, input bit h);
        int clr;
        bit was_door;
        int old_floor;
        clr       = -1;
        was_door  = m_door;
        old_floor = m_floor;
        m_err     = v && (fl >= N);
        if (!m_moving && !m_door) begin
            if (m_pend[m_floor]) begin
                clr = m_floor; m_door = 1'b1; m_timer = 0;
            end else if (any_beyond(m_floor, m_up)) begin
                m_moving = 1'b1;
            end else if (any_beyond(m_floor, !m_up)) begin
                m_up = !m_up; m_moving = 1'b1;
            end
        end else if (m_moving) begin
            if (m_timer == MOVE - 1) begin
                m_timer = 0;
                m_floor = m_up ? m_floor + 1 : m_floor - 1;
                if (m_pend[m_floor]) begin
                    clr = m_floor; m_moving = 1'b0; m_door = 1'b1;
                end else if (!any_beyond(m_floor, m_up)) begin
                    m_moving = 1'b0;
                end
            end else begin
                m_timer++;
            end
        end else begin
            if (v && fl == m_floor) m_timer = 0;
            else if (!h) begin
                if (m_timer == DOOR - 1) begin
                    m_timer = 0; m_door = 1'b0;
                end else begin
                    m_timer++;
                end
            end
        end
        if (v && fl < N && fl != clr && !(was_door && fl == old_floor)) m_pend[fl] = 1'b1;
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    task automatic compare_all();
        check("cur_floor", 32'(cur_floor), 32'(m_floor));
        check("dir_up", 32'(dir_up), 32'(m_up));
        check("moving", 32'(moving), 32'(m_moving));
        check("door_open", 32'(door_open), 32'(m_door));
        check("pending", 32'(pending), 32'(pend_vec()));
        check("call_err", 32'(call_err), 32'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model, and compare at the next falling edge.
    task automatic step(input logic v, input logic [FW-1:0] f, input logic h);
        call_valid = v;
        call_floor = f;
        door_hold  = h;
        model_step(v, int'(f), h);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        call_valid = 1'b0; call_floor = '0; door_hold = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        int door_cnt;
        int served[$];
        bit prev_door;
        bit found;
        bit dir_at_zero;

        rst = 1'b1;
        call_valid = 1'b0; call_floor = '0; door_hold = 1'b0;
        model_reset();

        // Single call: floor 0 to floor 3.
        do_reset();
        step(1'b1, 4'd3, 1'b0);
        check("single_pending_c1", 32'(pending), 32'h08);
        idle(1);
        check("single_moving_c2", 32'(moving), 32'd1);
        idle(4);
        check("single_floor_c6", 32'(cur_floor), 32'd1);
        idle(4);
        check("single_floor_c10", 32'(cur_floor), 32'd2);
        idle(4);
        check("single_floor_c14", 32'(cur_floor), 32'd3);
        check("single_door_c14", 32'(door_open), 32'd1);
        idle(2);
        check("single_door_c16", 32'(door_open), 32'd1);
        idle(1);
        check("single_door_c17", 32'(door_open), 32'd0);
        check("single_moving_c17", 32'(moving), 32'd0);
        check("single_pending_c17", 32'(pending), 32'd0);

        // SCAN order: call 5, then 2 and 0 while travelling up.
        do_reset();
        step(1'b1, 4'd5, 1'b0);
        idle(6);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        prev_door   = door_open;
        dir_at_zero = 1'b1;
        for (int i = 0; i < 300 && served.size() < 3; i++) begin
            idle(1);
            if (door_open && !prev_door) begin
                served.push_back(int'(cur_floor));
                if (cur_floor == 0) dir_at_zero = dir_up;
            end
            prev_door = door_open;
        end
        check("scan_stops", 32'(served.size()), 32'd3);
        if (served.size() == 3) begin
            check("scan_first", 32'(served[0]), 32'd2);
            check("scan_second", 32'(served[1]), 32'd5);
            check("scan_third", 32'(served[2]), 32'd0);
            check("scan_dir_down", 32'(dir_at_zero), 32'd0);
        end

        // Same-floor call with a restart of the dwell.
        do_reset();
        step(1'b1, 4'd0, 1'b0);
        idle(1);
        check("same_door_c2", 32'(door_open), 32'd1);
        idle(1);
        step(1'b1, 4'd0, 1'b0);
        idle(2);
        check("same_door_c6", 32'(door_open), 32'd1);
        check("same_pending_c6", 32'(pending), 32'd0);
        idle(1);
        check("same_door_c7", 32'(door_open), 32'd0);

        // Door hold for five cycles stretches the dwell to 3+5.
        step(1'b1, 4'd0, 1'b0);
        idle(1);
        door_cnt = int'(door_open);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            door_cnt += int'(door_open);
        end
        for (int i = 0; i < 10; i++) begin
            idle(1);
            door_cnt += int'(door_open);
        end
        check("hold_door_cycles", 32'(door_cnt), 32'd8);

        // Out-of-range calls.
        step(1'b1, 4'd9, 1'b0);
        check("err9_pulse", 32'(call_err), 32'd1);
        check("err9_pending", 32'(pending), 32'd0);
        idle(1);
        check("err9_clear", 32'(call_err), 32'd0);
        check("err9_no_move", 32'(moving), 32'd0);
        step(1'b1, 4'd8, 1'b0);
        check("err8_pulse", 32'(call_err), 32'd1);

        // Reset in the middle of travel at floor 2.
        do_reset();
        step(1'b1, 4'd5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            idle(1);
            if (cur_floor == 2 && moving) found = 1'b1;
        end
        check("rst_reach_floor2", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_floor", 32'(cur_floor), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_all();

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 499) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 5) == 0),
                     FW'($urandom_range(0, 10)),
                     ($urandom_range(0, 7) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
